// File: rtl/button_mode_frontend_if.sv
// Button front-end bus: raw board buttons in, one-hot mode code and command pulses out.
interface button_mode_frontend_if;
  logic       btn_mode_raw;
  logic       btn_start_raw;
  logic       btn_reset_raw;
  logic [2:1] btn_raw;
  logic [3:0] state;
  logic       start_pulse;
  logic       reset_pulse;
  logic [2:1] button_pulse;

  // Board side: drives the raw buttons, consumes mode code and pulses.
  modport master (
    output btn_mode_raw,
    output btn_start_raw,
    output btn_reset_raw,
    output btn_raw,
    input  state,
    input  start_pulse,
    input  reset_pulse,
    input  button_pulse
  );

  // Front-end side.
  modport slave (
    input  btn_mode_raw,
    input  btn_start_raw,
    input  btn_reset_raw,
    input  btn_raw,
    output state,
    output start_pulse,
    output reset_pulse,
    output button_pulse
  );
endinterface

// File: rtl/button_mode_frontend.sv
// Button front end: synchronise and debounce raw buttons, turn presses into one-cycle
// pulses, run the mode state machine and auto-repeat the two digit-increment keys.
module button_mode_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter logic [3:0]  REPEAT_EN_MASK  = 4'b0011
) (
  input logic                   clk,
  input logic                   reset,
  button_mode_frontend_if.slave bus
);

  // Input lanes: 0 mode, 1 start, 2 user reset, 3 button[1], 4 button[2].
  localparam int unsigned NumIn    = 5;
  localparam int unsigned IdxMode  = 0;
  localparam int unsigned IdxStart = 1;
  localparam int unsigned IdxReset = 2;
  localparam int unsigned IdxB1    = 3;

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RepW  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldFull = HoldW'(HOLD_CYCLES);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

  // Hold time is measured from the raw press, so the hold counter starts at the
  // press-pulse latency (2 sync + debounce + edge + output register).
  localparam int unsigned HoldSeedInt = (DEBOUNCE_CYCLES + 3 < HOLD_CYCLES) ?
                                        DEBOUNCE_CYCLES + 3 : 0;
  localparam logic [HoldW-1:0] HoldSeed = HoldW'(HoldSeedInt);

  // Mode codes (one-hot, CLOCK is all-zero).
  localparam logic [3:0] StClock     = 4'b0000;
  localparam logic [3:0] StCountUp   = 4'b1000;
  localparam logic [3:0] StCountDown = 4'b0100;
  localparam logic [3:0] StAlarm     = 4'b0010;
  localparam logic [3:0] StSetup     = 4'b0001;

  logic [NumIn-1:0] raw;
  logic [NumIn-1:0] sync1_q, sync2_q;
  logic [NumIn-1:0] deb_q, deb_d, deb_prev_q;
  logic [NumIn-1:0] armed_q, armed_d;
  logic [NumIn-1:0] edge_q, edge_d;
  logic [NumIn-1:0] pulse_q, pulse_d;
  logic [DebW-1:0]  deb_cnt_q [NumIn];
  logic [DebW-1:0]  deb_cnt_d [NumIn];
  logic [1:0]       prime_q;

  logic [1:0]       holding_q, holding_d, fire;
  logic [HoldW-1:0] hold_cnt_q [2];
  logic [HoldW-1:0] hold_cnt_d [2];
  logic [RepW-1:0]  rep_cnt_q [2];
  logic [RepW-1:0]  rep_cnt_d [2];

  logic [3:0] state_q, state_d;
  logic       rep_en;
  logic       mode_adv;

  assign raw = {bus.btn_raw[2], bus.btn_raw[1], bus.btn_reset_raw, bus.btn_start_raw,
                bus.btn_mode_raw};

  // Two-flop synchronisers, plus a primer that marks when the synchronisers hold real data.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge detect, gated until each input has been seen low after reset.
  always_comb begin
    armed_d = armed_q | ({NumIn{prime_q[1]}} & ~sync2_q);
    edge_d  = deb_q & ~deb_prev_q & armed_q;
  end

  // Auto-repeat for button[2:1]: seed on the press pulse, fire at hold, then periodically.
  always_comb begin
    rep_en   = |(state_q & REPEAT_EN_MASK);
    mode_adv = pulse_q[IdxMode];
    for (int j = 0; j < 2; j++) begin
      holding_d[j]  = holding_q[j];
      hold_cnt_d[j] = hold_cnt_q[j];
      rep_cnt_d[j]  = rep_cnt_q[j];
      fire[j]       = 1'b0;
      if (!deb_q[IdxB1 + j] || !rep_en || mode_adv) begin
        holding_d[j]  = 1'b0;
        hold_cnt_d[j] = '0;
        rep_cnt_d[j]  = '0;
      end else if (edge_q[IdxB1 + j]) begin
        holding_d[j]  = 1'b1;
        hold_cnt_d[j] = HoldSeed;
        rep_cnt_d[j]  = '0;
      end else if (holding_q[j]) begin
        if (hold_cnt_q[j] != HoldFull) begin
          if (hold_cnt_q[j] == HoldLast) begin
            fire[j]      = 1'b1;
            rep_cnt_d[j] = '0;
          end
          hold_cnt_d[j] = hold_cnt_q[j] + 1'b1;
        end else if (rep_cnt_q[j] == RepLast) begin
          fire[j]      = 1'b1;
          rep_cnt_d[j] = '0;
        end else begin
          rep_cnt_d[j] = rep_cnt_q[j] + 1'b1;
        end
      end
    end
  end

  // Output pulses merge press edges with repeat fires on the two auxiliary lanes.
  always_comb begin
    pulse_d = edge_q | {fire, 3'b000};
  end

  // Mode state machine; any illegal code falls back to CLOCK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StClock:     if (mode_adv) state_d = StCountUp;
      StCountUp:   if (mode_adv) state_d = StCountDown;
      StCountDown: if (mode_adv) state_d = StAlarm;
      StAlarm:     if (mode_adv) state_d = StSetup;
      StSetup:     if (mode_adv) state_d = StClock;
      default:     state_d = StClock;
    endcase
  end

  // Debounce, edge and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      armed_q    <= '0;
      edge_q     <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < NumIn; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      armed_q    <= armed_d;
      edge_q     <= edge_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < NumIn; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Hold/repeat counters and mode register.
  always_ff @(posedge clk) begin
    if (reset) begin
      holding_q <= '0;
      state_q   <= StClock;
      for (int j = 0; j < 2; j++) begin
        hold_cnt_q[j] <= '0;
        rep_cnt_q[j]  <= '0;
      end
    end else begin
      holding_q <= holding_d;
      state_q   <= state_d;
      for (int j = 0; j < 2; j++) begin
        hold_cnt_q[j] <= hold_cnt_d[j];
        rep_cnt_q[j]  <= rep_cnt_d[j];
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.start_pulse  = pulse_q[IdxStart];
  assign bus.reset_pulse  = pulse_q[IdxReset];
  assign bus.button_pulse = pulse_q[IdxB1 + 1 : IdxB1];

endmodule

// File: doc/button_mode_frontend.md
Name: button_mode_frontend

Overview:
- Front end that produces the one-hot mode code and the single-cycle command pulses consumed by the mode signal router.
- Synchronises and debounces the raw board push-buttons, then converts presses into one-cycle pulses.
- Owns the mode state machine, which a dedicated mode button advances.
- Provides auto-repeat on button[2:1] while held, so the SETUP/ALARM digit-increment keys can scroll.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised samples required before a level change is accepted. Bench uses 4.
- HOLD_CYCLES, 50000000: cycles a debounced button[2:1] must stay high before auto-repeat starts. Bench uses 20.
- REPEAT_CYCLES, 10000000: period between auto-repeat pulses after HOLD_CYCLES. Bench uses 8.
- REPEAT_EN_MASK, 4'b0011: auto-repeat is enabled only in modes whose state bit is set in this mask (default ALARM, SETUP).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high system reset.
- btn_mode_raw, input, 1: raw mode-select button, asynchronous, active-high.
- btn_start_raw, input, 1: raw start button.
- btn_reset_raw, input, 1: raw user-reset button.
- btn_raw, input, [2:1]: raw auxiliary buttons.
- state, output, [3:0]: one-hot mode code. 0000 = CLOCK, 1000 = COUNTUP, 0100 = COUNTDOWN, 0010 = ALARM, 0001 = SETUP.
- start_pulse, output, 1: one-cycle start command.
- reset_pulse, output, 1: one-cycle user-reset command.
- button_pulse, output, [2:1]: one-cycle auxiliary commands, including auto-repeat pulses.

Behaviour:
- Reset: while reset is high, at every clk edge:
  - state = 0000 (CLOCK).
  - All pulse outputs = 0.
  - Synchroniser flops, debounced levels, debounce counters and hold/repeat counters = 0.
- Reset held across a press: a raw input already high when reset deasserts must not produce a pulse until it has been released and pressed again. The debounced level starts at 0, so it is accepted as a rise. Gate this by latching "seen low since reset" per input; the edge detector ignores rises until the latch is set.
- Synchroniser: each of the 5 raw inputs passes through 2 flops.
- Debounce, per input:
  - Counter increments while the synchronised value differs from the debounced level.
  - Counter clears to 0 whenever they are equal.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- Edge detect: a 0->1 transition of a debounced level produces a registered pulse exactly 1 cycle wide.
- Latency: a raw rise sampled at edge k, then held, gives a pulse high during cycle k+DEBOUNCE_CYCLES+3. Releases produce no pulse.
- Mode FSM:
  - On a mode-button pulse, state advances to the next mode in the cycle following the pulse.
  - Order: CLOCK -> COUNTUP -> COUNTDOWN -> ALARM -> SETUP -> CLOCK (wrap).
  - state is always one of the 5 legal codes. Any illegal value recovers to 0000 on the next edge.
- Mode press gives no other pulse: a mode press never asserts start_pulse, reset_pulse or button_pulse.
- Simultaneous events: if a mode pulse and another button pulse occur in the same cycle, the other pulse is still emitted that cycle. The router therefore sees it under the old state. state changes on the following edge.
- Auto-repeat, button[n]:
  - Enabled only while (state & REPEAT_EN_MASK) != 0.
  - After the initial press pulse, the hold counter counts while the debounced level stays high.
  - At HOLD_CYCLES an extra pulse is emitted. Further pulses follow every REPEAT_CYCLES while the level stays high.
  - Release clears the counters immediately.
  - A mode change clears the counters, so repeat restarts only on a new press.
  - button[1] and button[2] repeat independently. Both may pulse in the same cycle.
- Pulse width: no pulse output is ever high for 2 consecutive cycles. With REPEAT_CYCLES >= 2 this holds by construction.
- Counter widths: use $clog2(param+1) bits. Counters saturate and never wrap.

Test Plan:
- Reset and release: assert reset 3 cycles with btn_start_raw high, then release reset and keep it held 40 cycles -> state = 0000, no start_pulse.
- Clean start press: raw press held 10 cycles at edge k -> start_pulse high only in cycle k+7 (DEBOUNCE_CYCLES = 4). No pulse on release.
- Glitch rejection: btn_reset_raw high for 3 cycles, then low -> no reset_pulse. High for 6 cycles -> exactly one reset_pulse.
- Mode cycling: 6 mode presses -> state sequence 1000, 0100, 0010, 0001, 0000, 1000. Zero other pulses throughout.
- Simultaneous press: mode and start presses aligned from CLOCK -> start_pulse in a cycle where state = 0000. Next cycle state = 1000.
- Auto-repeat: in SETUP, hold btn_raw[1] for 60 cycles -> pulses at press+7, +20, +28, +36, ... In COUNTUP, the same hold gives exactly 1 pulse.
